// File: rtl/attn_sum_spike_encoder.sv
// Per-lane integrate-and-fire neurons that turn popcount sums back into spike vectors.
// One token is TIME_STEPS accepted beats; membranes clear after the last beat of a token.
//
// state | meaning
// IDLE  | no token open, step counter at 0
// RUN   | token in progress, step counter points at the next beat's time step
module attn_sum_spike_encoder #(
  parameter  int LANES      = 8,
  parameter  int SUM_W      = 4,
  parameter  int MEM_W      = 8,
  parameter  int VTH        = 4,
  parameter  int TIME_STEPS = 4,
  localparam int STEP_W     = (TIME_STEPS > 1) ? $clog2(TIME_STEPS) : 1
) (
  input  logic                   s_clk,
  input  logic                   s_rst_n,
  input  logic                   i_clear,
  input  logic                   i_sum_valid,
  output logic                   o_sum_ready,
  input  logic [LANES*SUM_W-1:0] i_sum_data,
  output logic                   o_spike_valid,
  input  logic                   i_spike_ready,
  output logic [LANES-1:0]       o_spikes,
  output logic [STEP_W-1:0]      o_step,
  output logic                   o_last
);

  localparam int ACC_W = ((MEM_W > SUM_W) ? MEM_W : SUM_W) + 1;
  localparam logic [ACC_W-1:0]  MEM_MAX   = ACC_W'((2 ** MEM_W) - 1);
  localparam logic [ACC_W-1:0]  VTH_A     = ACC_W'(VTH);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TIME_STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [MEM_W-1:0]  mem_q [LANES];
  logic [MEM_W-1:0]  mem_d [LANES];
  logic [ACC_W-1:0]  acc   [LANES];
  logic [ACC_W-1:0]  sat   [LANES];
  logic [LANES-1:0]  spike_d;
  logic              accept;
  logic              is_last;

  // Ready is combinational so a draining output slot can be refilled in the same cycle.
  assign o_sum_ready = (!o_spike_valid || i_spike_ready) && !i_clear;
  assign accept      = i_sum_valid && o_sum_ready;
  assign is_last     = (step_q == LAST_STEP);

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (i_clear) begin
      state_d = IDLE;
      step_d  = '0;
    end else if (accept) begin
      if (is_last) begin
        state_d = IDLE;
        step_d  = '0;
      end else begin
        state_d = RUN;
        step_d  = step_q + 1'b1;
      end
    end
  end

  // Soft reset keeps the residue above threshold so surplus charge fires on later steps.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      acc[k]     = ACC_W'(mem_q[k]) + ACC_W'(i_sum_data[k*SUM_W +: SUM_W]);
      sat[k]     = (acc[k] > MEM_MAX) ? MEM_MAX : acc[k];
      spike_d[k] = (sat[k] >= VTH_A);
      mem_d[k]   = spike_d[k] ? MEM_W'(sat[k] - VTH_A) : MEM_W'(sat[k]);
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int k = 0; k < LANES; k++) mem_q[k] <= '0;
    end else if (i_clear || (accept && is_last)) begin
      for (int k = 0; k < LANES; k++) mem_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < LANES; k++) mem_q[k] <= mem_d[k];
    end
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      o_spike_valid <= 1'b0;
      o_spikes      <= '0;
      o_step        <= '0;
      o_last        <= 1'b0;
    end else if (i_clear) begin
      o_spike_valid <= 1'b0;
      o_spikes      <= '0;
      o_step        <= '0;
      o_last        <= 1'b0;
    end else if (accept) begin
      o_spike_valid <= 1'b1;
      o_spikes      <= spike_d;
      o_step        <= step_q;
      o_last        <= is_last;
    end else if (i_spike_ready) begin
      o_spike_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_attn_sum_spike_encoder.sv
// Bench for attn_sum_spike_encoder: a reference IF model fills a scoreboard on every input
// accept and a negedge monitor pops it on every output handshake.
module tb_attn_sum_spike_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        sum_valid;
  logic        sum_ready;
  logic [31:0] sum_data;
  logic        spike_valid;
  logic        spike_ready;
  logic [7:0]  spikes;
  logic [1:0]  step;
  logic        last;

  logic        sum_valid2;
  logic        sum_ready2;
  logic [31:0] sum_data2;
  logic        spike_valid2;
  logic [7:0]  spikes2;
  logic [1:0]  step2;
  logic        last2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] spikes;
    logic [1:0] step;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    mdl_mem[8];
  int    mdl_step;

  always #5 clk = ~clk;

  attn_sum_spike_encoder dut (
    .s_clk(clk), .s_rst_n(rst_n), .i_clear(clear),
    .i_sum_valid(sum_valid), .o_sum_ready(sum_ready), .i_sum_data(sum_data),
    .o_spike_valid(spike_valid), .i_spike_ready(spike_ready),
    .o_spikes(spikes), .o_step(step), .o_last(last)
  );

  attn_sum_spike_encoder #(.MEM_W(4)) dut_narrow (
    .s_clk(clk), .s_rst_n(rst_n), .i_clear(1'b0),
    .i_sum_valid(sum_valid2), .o_sum_ready(sum_ready2), .i_sum_data(sum_data2),
    .o_spike_valid(spike_valid2), .i_spike_ready(1'b1),
    .o_spikes(spikes2), .o_step(step2), .o_last(last2)
  );

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) mdl_mem[k] = 0;
    mdl_step = 0;
  endfunction

  function automatic void model_accept(input logic [31:0] d);
    beat_t b;
    int    acc;
    b.spikes = '0;
    b.step   = 2'(mdl_step);
    b.last   = (mdl_step == 3);
    for (int k = 0; k < 8; k++) begin
      acc = mdl_mem[k] + int'(d[k*4 +: 4]);
      if (acc > 255) acc = 255;
      b.spikes[k] = (acc >= 4);
      mdl_mem[k]  = b.spikes[k] ? acc - 4 : acc;
    end
    if (b.last) begin
      model_reset();
    end else begin
      mdl_step++;
    end
    exp_q.push_back(b);
  endfunction

  always @(negedge clk) begin
    if (rst_n && spike_valid && spike_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got spikes=%h step=%0d last=%0b, required no beat",
                 spikes, step, last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({spikes, step, last} !== mon_e) begin
          n_fail++;
          $display("FAIL out_beat: got spikes=%h step=%0d last=%0b, required spikes=%h step=%0d last=%0b",
                   spikes, step, last, mon_e.spikes, mon_e.step, mon_e.last);
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d);
    int n = 0;
    sum_valid = 1'b1;
    sum_data  = d;
    @(negedge clk);
    while (!sum_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got sum_ready=0, required 1 within 50 cycles");
    end else begin
      model_accept(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sum_valid = 1'b0;
    sum_data  = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({spike_valid, spikes, step, last} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b spikes=%h step=%0d last=%0b, required all 0",
               spike_valid, spikes, step, last);
    end
    n_checks++;
    if (sum_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %0b, required 1", sum_ready);
    end
    n_checks++;
    if ({spike_valid2, spikes2, step2, last2} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_narrow: got valid=%0b spikes=%h, required 0", spike_valid2, spikes2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_uniform();
    for (int i = 0; i < 4; i++) send_beat(32'h3333_3333);
    idle();
    drain();
  endtask

  task automatic test_lane0_carry();
    for (int i = 0; i < 4; i++) send_beat(32'h0000_0008);
    send_beat(32'h0000_0001);
    for (int i = 0; i < 3; i++) send_beat(32'h0000_0000);
    idle();
    drain();
  endtask

  task automatic test_backpressure();
    spike_ready = 1'b0;
    send_beat(32'h5555_5555);
    sum_valid = 1'b1;
    sum_data  = 32'h0000_00F2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (sum_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_ready: got %0b, required 0", sum_ready);
      end
      n_checks++;
      if (spike_valid !== 1'b1 || exp_q.size() == 0 ||
          {spikes, step, last} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL hold_stable: got valid=%0b spikes=%h step=%0d", spike_valid, spikes, step);
      end
    end
    @(posedge clk);
    #1;
    spike_ready = 1'b1;
    send_beat(32'h0000_00F2);
    send_beat(32'h1234_5678);
    n_checks++;
    if (spike_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: got valid=%0b, required 1", spike_valid);
    end
    send_beat(32'h8765_4321);
    n_checks++;
    if (spike_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: got valid=%0b, required 1", spike_valid);
    end
    idle();
    drain();
  endtask

  task automatic test_clear();
    send_beat(32'h3333_3333);
    send_beat(32'h3333_3333);
    clear     = 1'b1;
    sum_valid = 1'b1;
    sum_data  = 32'h7777_7777;
    @(negedge clk);
    n_checks++;
    if (sum_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready: got %0b, required 0", sum_ready);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    idle();
    model_reset();
    n_checks++;
    if (spike_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_valid: got %0b, required 0", spike_valid);
    end
    for (int i = 0; i < 4; i++) send_beat(32'h3333_3333);
    idle();
    drain();
  endtask

  task automatic test_saturate_narrow();
    for (int i = 0; i < 4; i++) begin
      sum_valid2 = 1'b1;
      sum_data2  = 32'h0000_F000;
      @(negedge clk);
      n_checks++;
      if (sum_ready2 !== 1'b1) begin
        n_fail++;
        $display("FAIL narrow_ready: got %0b, required 1", sum_ready2);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({spike_valid2, spikes2, step2, last2} !== {1'b1, 8'h08, 2'(i), (i == 3)}) begin
        n_fail++;
        $display("FAIL narrow_sat: got valid=%0b spikes=%h step=%0d last=%0b, required 1 08 %0d %0b",
                 spike_valid2, spikes2, step2, last2, i, (i == 3));
      end
    end
    sum_valid2 = 1'b0;
    sum_data2  = '0;
  endtask

  task automatic test_async_reset();
    spike_ready = 1'b0;
    send_beat(32'h5555_5555);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({spike_valid, spikes, step, last} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%0b spikes=%h step=%0d last=%0b, required all 0",
               spike_valid, spikes, step, last);
    end
    exp_q.delete();
    model_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    spike_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(32'h5555_5555);
    idle();
    drain();
  endtask

  initial begin
    rst_n       = 1'b0;
    clear       = 1'b0;
    sum_valid   = 1'b0;
    sum_data    = '0;
    spike_ready = 1'b1;
    sum_valid2  = 1'b0;
    sum_data2   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_uniform();
    test_lane0_carry();
    test_backpressure();
    test_clear();
    test_saturate_narrow();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
